// File: rtl/cache_burst_transfer.sv
// Moves one cache line between the cache and an AXI master, one beat at a time (refill or writeback).
// Define CACHE_BURST_WRAP_EN for critical-word-first (wrap) beat order and the o_critical_valid output.
module cache_burst_transfer #(
  parameter  int AXI_DATA_WIDTH = 32,
  parameter  int AXI_ADDR_WIDTH = 64,
  parameter  int BLOCK_WIDTH    = 512,
  localparam int BEATS          = BLOCK_WIDTH / AXI_DATA_WIDTH,
  localparam int BYTES          = AXI_DATA_WIDTH / 8,
  localparam int IDX_W          = $clog2(BEATS)
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      i_start_read,
  input  logic                      i_start_write,
  input  logic [AXI_ADDR_WIDTH-1:0] i_addr_cache,
  input  logic [BLOCK_WIDTH-1:0]    i_data_block_cache,
  input  logic                      i_beat_done,
  input  logic [AXI_DATA_WIDTH-1:0] i_data_axi,
  input  logic                      i_axi_error,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error,
  output logic                      o_last,
  output logic [IDX_W-1:0]          o_beat_idx,
  output logic [AXI_ADDR_WIDTH-1:0] o_addr_axi,
  output logic [AXI_DATA_WIDTH-1:0] o_data_axi,
  output logic [BLOCK_WIDTH-1:0]    o_data_block_cache
`ifdef CACHE_BURST_WRAP_EN
  ,
  output logic                      o_critical_valid
`endif
);

  localparam int OFF_LSB  = $clog2(BYTES);
  localparam int LINE_LSB = $clog2(BLOCK_WIDTH / 8);
  localparam int SUM_W    = IDX_W + 1;
  localparam logic [SUM_W-1:0]          BEATS_S   = SUM_W'(BEATS);
  localparam logic [IDX_W-1:0]          LAST_N    = IDX_W'(BEATS - 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] LINE_MASK = AXI_ADDR_WIDTH'((BLOCK_WIDTH / 8) - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;
  logic [IDX_W-1:0]          offset_q, offset_d;
  logic [IDX_W-1:0]          n_q, n_d;
  logic [BLOCK_WIDTH-1:0]    wline_q, wline_d;
  logic [BLOCK_WIDTH-1:0]    rline_q, rline_d;
  logic                      error_q, error_d;
  logic [SUM_W-1:0]          idx_sum_s;
  logic [IDX_W-1:0]          idx_s;
  logic                      busy_s;
  logic                      last_s;

  // Beat index wraps at the line boundary: (offset + n) mod BEATS.
  always_comb begin
    idx_sum_s = {1'b0, offset_q} + {1'b0, n_q};
    if (idx_sum_s >= BEATS_S) begin
      idx_s = IDX_W'(idx_sum_s - BEATS_S);
    end else begin
      idx_s = IDX_W'(idx_sum_s);
    end
    busy_s = (state_q == S_READ) || (state_q == S_WRITE);
    last_s = busy_s && (n_q == LAST_N);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    offset_d = offset_q;
    n_d      = n_q;
    wline_d  = wline_q;
    rline_d  = rline_q;
    error_d  = error_q;
    case (state_q)
      S_IDLE: begin
        if (i_start_write || i_start_read) begin
          state_d = i_start_write ? S_WRITE : S_READ;
          base_d  = i_addr_cache & ~LINE_MASK;
`ifdef CACHE_BURST_WRAP_EN
          offset_d = i_addr_cache[LINE_LSB-1:OFF_LSB];
`else
          offset_d = '0;
`endif
          n_d     = '0;
          wline_d = i_data_block_cache;
          error_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ, S_WRITE: begin
        if (i_beat_done) begin
          if (state_q == S_READ) begin
            rline_d[idx_s*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = i_data_axi;
          end else begin
            rline_d = rline_q;
          end
          if (i_axi_error) begin
            error_d = 1'b1;
          end else begin
            error_d = error_q;
          end
          // Counter saturates at the final beat; termination comes from the compare.
          if (last_s || i_axi_error) begin
            state_d = S_DONE;
          end else begin
            n_d = n_q + IDX_W'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      offset_q <= '0;
      n_q      <= '0;
      wline_q  <= '0;
      rline_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      offset_q <= offset_d;
      n_q      <= n_d;
      wline_q  <= wline_d;
      rline_q  <= rline_d;
      error_q  <= error_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    o_busy             = busy_s;
    o_done             = (state_q == S_DONE);
    o_error            = error_q;
    o_last             = last_s;
    o_beat_idx         = idx_s;
    o_addr_axi         = base_q + (AXI_ADDR_WIDTH'(idx_s) << OFF_LSB);
    o_data_block_cache = rline_q;
    if (state_q == S_WRITE) begin
      o_data_axi = wline_q[idx_s*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    end else begin
      o_data_axi = '0;
    end
  end

`ifdef CACHE_BURST_WRAP_EN
  logic crit_q, crit_d;

  // First refill beat carries the requested word, so flag it for an early restart.
  always_comb begin
    crit_d = (state_q == S_READ) && i_beat_done && (n_q == '0);
  end

  // Critical-word pulse register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      crit_q <= 1'b0;
    end else begin
      crit_q <= crit_d;
    end
  end

  assign o_critical_valid = crit_q;
`endif

endmodule

// File: tb/tb_cache_burst_transfer.sv
// Directed bench for cache_burst_transfer: word-array reference model checked every cycle plus literal pins.
// Honours CACHE_BURST_WRAP_EN to exercise critical-word-first ordering.
module tb_cache_burst_transfer;
  localparam int DW = 32;
  localparam int AW = 64;
  localparam int BW = 512;
  localparam int NB = 16;

`ifdef CACHE_BURST_WRAP_EN
  localparam int          WRAP   = 1;
  localparam int          T1_OFF = 1;
  localparam logic [63:0] T1_A0  = 64'h0000_0000_1000_0044;
  localparam logic [63:0] T1_A15 = 64'h0000_0000_1000_0040;
`else
  localparam int          WRAP   = 0;
  localparam int          T1_OFF = 0;
  localparam logic [63:0] T1_A0  = 64'h0000_0000_1000_0040;
  localparam logic [63:0] T1_A15 = 64'h0000_0000_1000_007C;
`endif

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic sr = 1'b0, sw = 1'b0, bd = 1'b0, aerr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [BW-1:0] lin = '0;
  logic [DW-1:0] dax = '0;
  logic o_busy, o_done, o_error, o_last;
  logic [3:0] o_beat_idx;
  logic [AW-1:0] o_addr_axi;
  logic [DW-1:0] o_data_axi;
  logic [BW-1:0] o_data_block_cache;
  logic o_critical_valid;

  int checks = 0;
  int failures = 0;

  cache_burst_transfer #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
    .clk(clk), .arst(arst), .i_start_read(sr), .i_start_write(sw),
    .i_addr_cache(addr), .i_data_block_cache(lin), .i_beat_done(bd),
    .i_data_axi(dax), .i_axi_error(aerr), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error), .o_last(o_last), .o_beat_idx(o_beat_idx),
    .o_addr_axi(o_addr_axi), .o_data_axi(o_data_axi), .o_data_block_cache(o_data_block_cache)
`ifdef CACHE_BURST_WRAP_EN
    , .o_critical_valid(o_critical_valid)
`endif
  );
`ifndef CACHE_BURST_WRAP_EN
  assign o_critical_valid = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: transfer phase (0 idle, 1 refill, 2 writeback, 3 done) and line words.
  int          m_phase = 0;
  logic [63:0] m_base = '0;
  int          m_off = 0;
  int          m_n = 0;
  logic        m_err = 1'b0;
  logic        m_crit = 1'b0;
  logic [31:0] m_w [NB];
  logic [31:0] m_r [NB];

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_phase = 0; m_base = '0; m_off = 0; m_n = 0; m_err = 1'b0; m_crit = 1'b0;
      for (int j = 0; j < NB; j++) begin m_w[j] = '0; m_r[j] = '0; end
    end else begin
      m_crit = 1'b0;
      if (m_phase == 0) begin
        if (sw || sr) begin
          m_phase = sw ? 2 : 1;
          m_base  = addr - (addr % 64);
          m_off   = WRAP ? int'((addr % 64) / 4) : 0;
          m_n     = 0;
          m_err   = 1'b0;
          for (int j = 0; j < NB; j++) m_w[j] = lin[j*32 +: 32];
        end
      end else if (m_phase == 3) begin
        m_phase = 0;
      end else if (bd) begin
        if (m_phase == 1) begin
          m_r[(m_off + m_n) % NB] = dax;
          if (m_n == 0) m_crit = 1'b1;
        end
        if (aerr) m_err = 1'b1;
        if (aerr || m_n == NB - 1) m_phase = 3;
        else m_n = m_n + 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin : cmp
    logic [BW-1:0] eb;
    int ei;
    for (int j = 0; j < NB; j++) eb[j*32 +: 32] = m_r[j];
    ei = (m_off + m_n) % NB;
    chk("busy", o_busy, (m_phase == 1 || m_phase == 2));
    chk("done", o_done, m_phase == 3);
    chk("error", o_error, m_err);
    chk("last", o_last, (m_phase == 1 || m_phase == 2) && m_n == NB - 1);
    chk("wdata", o_data_axi, (m_phase == 2) ? m_w[ei] : 32'h0);
    chk("block", o_data_block_cache, eb);
    if (WRAP != 0) chk("crit", o_critical_valid, m_crit);
    if (m_phase == 1 || m_phase == 2) begin
      chk("beat_idx", o_beat_idx, ei);
      chk("addr", o_addr_axi, m_base + 64'(ei * 4));
    end
  end

  int done_cnt = 0;
  int crit_cnt = 0;
  int cap_n = 0;
  logic [63:0] cap_addr [256];
  logic [31:0] cap_data [256];

  // Event counters and per-beat capture for the literal checks.
  always @(negedge clk) begin
    if (o_done) done_cnt++;
    if (o_critical_valid) crit_cnt++;
  end
  always @(posedge clk) begin
    if (!arst && o_busy && bd && cap_n < 256) begin
      cap_addr[cap_n] = o_addr_axi;
      cap_data[cap_n] = o_data_axi;
      cap_n++;
    end
  end

  task automatic start(input logic r, input logic w, input logic [63:0] a, input logic [BW-1:0] line);
    sr = r; sw = w; addr = a; lin = line;
    @(posedge clk); #1;
    sr = 1'b0; sw = 1'b0;
  endtask

  task automatic run_beats(input int gap, input int err_beat, input logic [31:0] dbase, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
      bd = 1'b1; dax = dbase + 32'(k); aerr = (k == err_beat);
      @(posedge clk); #1;
      bd = 1'b0; aerr = 1'b0; dax = '0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  initial begin
    int c0, d0;
    logic [BW-1:0] line;
    #2;
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_addr", o_addr_axi, 64'h0);
    chk("rst_block", o_data_block_cache, '0);
    @(posedge clk); #1; arst = 1'b0;
    idle(1);

    // Refill with back-to-back beats.
    c0 = cap_n;
    start(1'b1, 1'b0, 64'h0000_0000_1000_0044, '0);
    chk("t1_busy", o_busy, 1'b1);
    chk("t1_addr0", o_addr_axi, T1_A0);
    run_beats(0, -1, 32'hA0, NB);
    chk("t1_done", o_done, 1'b1);
    chk("t1_err", o_error, 1'b0);
    idle(1);
    chk("t1_cap0", cap_addr[c0], T1_A0);
    chk("t1_cap15", cap_addr[c0 + 15], T1_A15);
    chk("t1_slice_first", o_data_block_cache[T1_OFF*32 +: 32], 32'hA0);

    // Writeback with a beat every third cycle.
    for (int k = 0; k < NB; k++) line[k*32 +: 32] = 32'h1111_0000 + 32'(k);
    c0 = cap_n; d0 = done_cnt;
    start(1'b0, 1'b1, 64'h0000_0000_3000_0000, line);
    run_beats(2, -1, 32'h0, NB);
    chk("t2_done", o_done, 1'b1);
    idle(4);
    chk("t2_done_pulses", done_cnt - d0, 1);
    chk("t2_wd0", cap_data[c0], 32'h1111_0000);
    chk("t2_wd15", cap_data[c0 + 15], 32'h1111_000F);

    // Simultaneous start picks writeback; read held from the done cycle starts after one idle cycle.
    for (int k = 0; k < NB; k++) line[k*32 +: 32] = 32'h2222_0000 + 32'(k);
    start(1'b1, 1'b1, 64'h0000_0000_3000_0040, line);
    chk("t3_write_first", o_data_axi, 32'h2222_0000);
    run_beats(0, -1, 32'h0, NB);
    chk("t3_done", o_done, 1'b1);
    sr = 1'b1; addr = 64'h0000_0000_5000_0000;
    @(posedge clk); #1;
    chk("t3_idle_gap", o_busy, 1'b0);
    @(posedge clk); #1;
    sr = 1'b0;
    chk("t3_read_started", o_busy, 1'b1);
    run_beats(0, -1, 32'hC0, NB);
    idle(1);

    // Error on beat 5 aborts the refill; later beats are ignored.
    start(1'b1, 1'b0, 64'h0000_0000_4000_0000, '0);
    run_beats(0, 5, 32'hE0, 6);
    chk("t4_done", o_done, 1'b1);
    chk("t4_err", o_error, 1'b1);
    bd = 1'b1; dax = 32'hFF;
    idle(3);
    bd = 1'b0; dax = '0;
    chk("t4_err_sticky", o_error, 1'b1);
    chk("t4_slice0", o_data_block_cache[0 +: 32], 32'hE0);
    chk("t4_slice5", o_data_block_cache[5*32 +: 32], 32'hE5);
    chk("t4_slice6", o_data_block_cache[6*32 +: 32], 32'hC6);

    // Reset after beat 7 of a writeback, then a clean refill.
    for (int k = 0; k < NB; k++) line[k*32 +: 32] = 32'h3333_0000 + 32'(k);
    start(1'b0, 1'b1, 64'h0000_0000_6000_0000, line);
    chk("t5_err_cleared", o_error, 1'b0);
    d0 = done_cnt;
    run_beats(0, -1, 32'h0, 8);
    arst = 1'b1; #1;
    chk("t5_busy", o_busy, 1'b0);
    chk("t5_done", o_done, 1'b0);
    chk("t5_last", o_last, 1'b0);
    chk("t5_idx", o_beat_idx, 4'h0);
    chk("t5_addr", o_addr_axi, 64'h0);
    chk("t5_wdata", o_data_axi, 32'h0);
    chk("t5_block", o_data_block_cache, '0);
    @(posedge clk); #1; arst = 1'b0;
    idle(2);
    chk("t5_no_done", done_cnt - d0, 0);
    start(1'b1, 1'b0, 64'h0000_0000_7000_0000, '0);
    run_beats(0, -1, 32'h50, NB);
    chk("t5_refill_done", o_done, 1'b1);
    idle(1);
    chk("t5_slice15", o_data_block_cache[15*32 +: 32], 32'h5F);

`ifdef CACHE_BURST_WRAP_EN
    // Critical-word-first refill wrapping at the line boundary.
    c0 = cap_n; d0 = crit_cnt;
    start(1'b1, 1'b0, 64'h0000_0000_2000_0038, '0);
    run_beats(0, -1, 32'h10, NB);
    chk("t6_done", o_done, 1'b1);
    idle(2);
    chk("t6_a0", cap_addr[c0], 64'h0000_0000_2000_0038);
    chk("t6_a1", cap_addr[c0 + 1], 64'h0000_0000_2000_003C);
    chk("t6_a2", cap_addr[c0 + 2], 64'h0000_0000_2000_0000);
    chk("t6_a15", cap_addr[c0 + 15], 64'h0000_0000_2000_0034);
    chk("t6_crit_pulses", crit_cnt - d0, 1);
    chk("t6_slice14", o_data_block_cache[14*32 +: 32], 32'h10);
`endif

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
